// File: rtl/quad_step_gen.sv
// quad_step_gen: quadrature A/B step generator.
// Accepts a command (direction, edge count, edge period in clocks) and emits
// one Gray-coded quadrature edge per step at the commanded spacing.
// Optional feature macro: QGEN_POS_EN adds a signed edge-position counter
// and the 'position' output port.

module quad_step_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             out_A,
  output logic             out_B,
  output logic             busy,
`ifdef QGEN_POS_EN
  output logic signed [POS_W-1:0] position,
`endif
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       phase;
  logic             dir;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] timer;

  logic             accept;
  logic [DIV_W-1:0] period_eff;
  logic             edge_due;
  logic             final_edge;
  logic             take_edge;
  logic [1:0]       next_phase;

  // Reject nonsensical parameterisations at elaboration time.
  if (CNT_W < 1 || DIV_W < 1 || POS_W < 2) begin : g_param_check
    $error("quad_step_gen: CNT_W/DIV_W must be >= 1 and POS_W >= 2");
  end

  assign cmd_ready  = (state == IDLE) && !reset;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state == RUN);

  // A zero period would never expire, so it is promoted to one clock.
  assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

  // The timer holds the clocks left until the next edge; an edge fires as it expires.
  assign edge_due   = (state == RUN) && (timer == DIV_W'(1));
  assign final_edge = edge_due && (remaining == CNT_W'(1));

  // Abort cancels any pending edge except the last one, which still lands but without done.
  assign take_edge  = edge_due && (!abort || final_edge);

  assign next_phase = dir ? (phase + 2'd1) : (phase - 2'd1);

  // Command sequencing, edge timing, Gray-coded outputs and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 2'd0;
      out_A     <= 1'b0;
      out_B     <= 1'b0;
      done      <= 1'b0;
      dir       <= 1'b0;
      remaining <= '0;
      period    <= '0;
      timer     <= '0;
`ifdef QGEN_POS_EN
      position  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dir       <= cmd_dir;
            remaining <= cmd_steps;
            period    <= period_eff;
            timer     <= period_eff;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (take_edge) begin
            phase     <= next_phase;
            out_A     <= next_phase[1];
            out_B     <= next_phase[1] ^ next_phase[0];
            remaining <= remaining - CNT_W'(1);
            timer     <= period;
`ifdef QGEN_POS_EN
            position  <= dir ? (position + POS_W'(1)) : (position - POS_W'(1));
`endif
          end else begin
            timer <= timer - DIV_W'(1);
          end
          if (final_edge) begin
            state <= IDLE;
            done  <= !abort;
          end else if (abort) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_step_gen.sv
// tb_quad_step_gen: self-checking bench for quad_step_gen.
// Table-driven commands feed a per-cycle expectation queue; hand-written
// sequences cover abort, abort on the final edge, reset mid-command and,
// when QGEN_POS_EN is defined, the position counter.

module tb_quad_step_gen;

  localparam int CNT_W = 16;
  localparam int DIV_W = 16;
  localparam int POS_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic             out_A;
  logic             out_B;
  logic             busy;
  logic             done;
`ifdef QGEN_POS_EN
  logic signed [POS_W-1:0] position;
`endif

  quad_step_gen #(
    .CNT_W(CNT_W),
    .DIV_W(DIV_W),
    .POS_W(POS_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .out_A     (out_A),
    .out_B     (out_B),
    .busy      (busy),
`ifdef QGEN_POS_EN
    .position  (position),
`endif
    .done      (done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct {
    logic  a;
    logic  b;
    logic  busy;
    logic  done;
    logic  ready;
    string name;
  } exp_t;

  typedef struct {
    logic       dir;
    int         steps;
    int         period;
    logic [1:0] final_ab;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   model_phase;
  int   checks;
  int   passes;

  // Phase to {A,B} as listed in the phase table: 0=00, 1=01, 2=11, 3=10.
  function automatic logic [1:0] ab_of(int ph);
    case (((ph % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic exp_t make_exp(int ph, logic bsy, logic dn, logic rdy, string nm);
    exp_t e;
    logic [1:0] ab;
    ab      = ab_of(ph);
    e.a     = ab[1];
    e.b     = ab[0];
    e.busy  = bsy;
    e.done  = dn;
    e.ready = rdy;
    e.name  = nm;
    return e;
  endfunction

  task automatic compare_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one command at a negedge and queue the expected output for every following cycle.
  task automatic applyStimulus(string tag, logic dir, int steps, int period, logic with_abort);
    int p_eff;
    int total;
    int sign;
    @(negedge clk);
    compare_val({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = steps[CNT_W-1:0];
    cmd_period = period[DIV_W-1:0];
    abort      = with_abort;
    p_eff      = (period == 0) ? 1 : period;
    sign       = dir ? 1 : -1;
    if (steps == 0) begin
      sb_q.push_back(make_exp(model_phase, 1'b0, 1'b1, 1'b1, $sformatf("%s_k0", tag)));
      sb_q.push_back(make_exp(model_phase, 1'b0, 1'b0, 1'b1, $sformatf("%s_k1", tag)));
    end else begin
      total = steps * p_eff;
      sb_q.push_back(make_exp(model_phase, 1'b1, 1'b0, 1'b0, $sformatf("%s_k0", tag)));
      for (int k = 1; k <= total; k++) begin
        sb_q.push_back(make_exp(model_phase + sign * (k / p_eff), k < total, k == total,
                                k == total, $sformatf("%s_k%0d", tag, k)));
      end
      model_phase = (((model_phase + sign * steps) % 4) + 4) % 4;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // Pop up to n queued expectations (all when n < 0), one per negedge.
  task automatic checkOutput(int n);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (sb_q.size() > 0 && (n < 0 || cnt < n)) begin
      @(negedge clk);
      e = sb_q.pop_front();
      compare_val({e.name, "_A"}, 32'(out_A), 32'(e.a));
      compare_val({e.name, "_B"}, 32'(out_B), 32'(e.b));
      compare_val({e.name, "_busy"}, 32'(busy), 32'(e.busy));
      compare_val({e.name, "_done"}, 32'(done), 32'(e.done));
      compare_val({e.name, "_ready"}, 32'(cmd_ready), 32'(e.ready));
      cnt++;
    end
  endtask

  task automatic check_idle(string tag, logic [1:0] ab);
    compare_val({tag, "_AB"}, 32'({out_A, out_B}), 32'(ab));
    compare_val({tag, "_busy"}, 32'(busy), 32'd0);
    compare_val({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset", 2'b00);
    compare_val("reset_ready", 32'(cmd_ready), 32'd0);
`ifdef QGEN_POS_EN
    compare_val("reset_position", 32'(position), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    compare_val("post_reset_ready", 32'(cmd_ready), 32'd1);
    model_phase = 0;
    sb_q.delete();
  endtask

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int start_ph;
    checks     = 0;
    passes     = 0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    abort      = 1'b0;
    model_phase = 0;

    vecs[0] = '{1'b1, 4, 1, 2'b00};
    vecs[1] = '{1'b0, 3, 5, 2'b01};
    vecs[2] = '{1'b0, 2, 0, 2'b10};
    vecs[3] = '{1'b1, 0, 3, 2'b10};
    vecs[4] = '{1'b1, 5, 2, 2'b00};
    vecs[5] = '{1'b0, 1, 1, 2'b10};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].dir, vecs[i].steps, vecs[i].period, 1'b0);
      checkOutput(-1);
      compare_val($sformatf("vec%0d_final_AB", i), 32'({out_A, out_B}), 32'(vecs[i].final_ab));
    end

    // Abort after the third edge of a forward run: outputs freeze at 10, no done.
    do_reset();
    applyStimulus("abort", 1'b1, 10, 2, 1'b0);
    checkOutput(7);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle("abort_stop", 2'b10);
    compare_val("abort_stop_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("abort_hold%0d", i), 2'b10);
    end
    sb_q.delete();
    model_phase = 3;
    applyStimulus("after_abort", 1'b0, 1, 1, 1'b0);
    checkOutput(-1);
    compare_val("after_abort_AB", 32'({out_A, out_B}), 32'(2'b11));

    // Abort landing on the final edge: the edge happens, done stays low.
    applyStimulus("abort_final", 1'b1, 2, 1, 1'b0);
    checkOutput(2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle("abort_final_edge", 2'b00);
    compare_val("abort_final_ready", 32'(cmd_ready), 32'd1);
    sb_q.delete();
    model_phase = 0;

    // Abort while idle is ignored; the simultaneous command runs normally.
    applyStimulus("idle_abort", 1'b1, 1, 1, 1'b1);
    checkOutput(-1);
    compare_val("idle_abort_AB", 32'({out_A, out_B}), 32'(2'b01));

    // Reset during a long command; a new command while busy is ignored.
    start_ph = model_phase;
    applyStimulus("mid_reset", 1'b1, 100, 3, 1'b0);
    checkOutput(6);
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b0;
    cmd_steps  = 16'd1;
    cmd_period = 16'd1;
    compare_val("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput(1);
    cmd_valid = 1'b0;
    compare_val("busy_ignored_AB", 32'({out_A, out_B}), 32'(ab_of(start_ph + 2)));
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_reset", 2'b00);
    compare_val("mid_reset_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    compare_val("mid_reset_release_ready", 32'(cmd_ready), 32'd1);
    check_idle("mid_reset_release", 2'b00);
    sb_q.delete();
    model_phase = 0;

`ifdef QGEN_POS_EN
    // Position counter: +8, -3, then -6 wraps to all ones.
    do_reset();
    applyStimulus("pos_fwd8", 1'b1, 8, 1, 1'b0);
    checkOutput(-1);
    compare_val("pos_after_fwd8", 32'(position), 32'd8);
    applyStimulus("pos_rev3", 1'b0, 3, 1, 1'b0);
    checkOutput(-1);
    compare_val("pos_after_rev3", 32'(position), 32'd5);
    applyStimulus("pos_rev6", 1'b0, 6, 1, 1'b0);
    checkOutput(-1);
    compare_val("pos_after_rev6", 32'(position), 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
